// File: rtl/elastic_buffer_pkg.sv
// Shared definitions for the RX elastic buffer read side.
// Contents: 8b/10b COM/SKP codes (both disparities), pointer-width
// derivation, buffer mode encodings, SKP scheduler FSM state type and a
// saturating subtract helper for the fill-level thresholds.
package elastic_buffer_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;  // COM, RD-
    localparam logic [9:0] K28_5_RDP = 10'h305;  // COM, RD+
    localparam logic [9:0] K28_0_RDN = 10'h0F4;  // SKP, RD-
    localparam logic [9:0] K28_0_RDP = 10'h30B;  // SKP, RD+

    typedef enum logic {
        MODE_NOMINAL_EMPTY = 1'b0,
        MODE_HALF_FULL     = 1'b1
    } eb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_OS    = 2'd1,
        ST_ADJ_DONE = 2'd2
    } skp_state_e;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int eb_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int eb_sat_sub(input int a, input int b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/elastic_buffer_skp_controller_gray_to_bin.sv
// Gray-to-binary converter, counterpart of binToGray.
// Ports: gray_i - gray-coded value, bin_o - binary equivalent.
module gray_to_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at and above it.
    always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/elastic_buffer_skp_controller.sv
// Read-side scheduler for the RX elastic buffer. Compares fill level with a
// mode-dependent target and inserts or deletes one SKP per SKP ordered set
// to absorb clock drift.
// Ports:
//   read_clk, rst       - read clock, synchronous active-high reset
//   buffer_mode         - 1 half-full target, 0 nominal-empty target
//   gray_write_pointer  - synchronized gray write pointer (PW bits)
//   read_address        - binary read pointer (PW bits)
//   head_symbol         - entry at read pointer; next_symbol - entry after it
//   rd_step             - read pointer increment this cycle (0/1/2)
//   data_out/data_valid - registered output symbol and qualifier
//   empty               - fill level is zero (combinational)
//   skp_added/removed   - registered one-cycle adjustment pulses
//   fill_level          - registered occupancy
module elastic_buffer_skp_controller
    import elastic_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 10,
    parameter int                    BUFFER_DEPTH = 16,
    parameter int                    HALF_TARGET  = 8,
    parameter int                    EMPTY_TARGET = 2,
    parameter int                    HYST         = 2,
    parameter logic [DATA_WIDTH-1:0] COM_RDN      = K28_5_RDN,
    parameter logic [DATA_WIDTH-1:0] COM_RDP      = K28_5_RDP,
    parameter logic [DATA_WIDTH-1:0] SKP_RDN      = K28_0_RDN,
    parameter logic [DATA_WIDTH-1:0] SKP_RDP      = K28_0_RDP,
    localparam int                   PW           = eb_ptr_width(BUFFER_DEPTH)
) (
    input  logic                  read_clk,
    input  logic                  rst,
    input  logic                  buffer_mode,
    input  logic [PW-1:0]         gray_write_pointer,
    input  logic [PW-1:0]         read_address,
    input  logic [DATA_WIDTH-1:0] head_symbol,
    input  logic [DATA_WIDTH-1:0] next_symbol,
    output logic [1:0]            rd_step,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  empty,
    output logic                  skp_added,
    output logic                  skp_removed,
    output logic [PW-1:0]         fill_level
);

    localparam logic [PW:0] HALF_HI  = (PW+1)'(HALF_TARGET + HYST);
    localparam logic [PW:0] HALF_LO  = (PW+1)'(eb_sat_sub(HALF_TARGET, HYST));
    localparam logic [PW:0] EMPTY_HI = (PW+1)'(EMPTY_TARGET + HYST);
    localparam logic [PW:0] EMPTY_LO = (PW+1)'(eb_sat_sub(EMPTY_TARGET, HYST));

    logic [PW-1:0]         wbin;
    logic [PW-1:0]         level;
    logic [PW:0]           level_x;
    logic [PW:0]           thr_hi;
    logic [PW:0]           thr_lo;
    logic                  want_rm;
    logic                  want_add;
    logic                  is_com;
    logic                  is_skp;
    logic                  next_is_skp;
    logic [1:0]            step_c;

    skp_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  add_q, add_d;
    logic                  rm_q, rm_d;
    logic [PW-1:0]         fill_q;

    gray_to_bin #(.WIDTH(PW)) u_gray_to_bin (
        .gray_i (gray_write_pointer),
        .bin_o  (wbin)
    );

    // Modulo subtraction: equal low bits with differing MSB yields BUFFER_DEPTH.
    assign level   = wbin - read_address;
    assign level_x = {1'b0, level};

    assign thr_hi   = (buffer_mode == MODE_HALF_FULL) ? HALF_HI : EMPTY_HI;
    assign thr_lo   = (buffer_mode == MODE_HALF_FULL) ? HALF_LO : EMPTY_LO;
    assign want_rm  = level_x > thr_hi;
    assign want_add = level_x < thr_lo;

    assign is_com      = (head_symbol == COM_RDN) || (head_symbol == COM_RDP);
    assign is_skp      = (head_symbol == SKP_RDN) || (head_symbol == SKP_RDP);
    assign next_is_skp = (next_symbol == SKP_RDN) || (next_symbol == SKP_RDP);

    // With an empty buffer the head entry is stale: hold the pointer, emit
    // nothing and leave the ordered-set tracking untouched.
    always_comb begin
        state_d = state_q;
        step_c  = 2'd0;
        data_d  = data_q;
        valid_d = 1'b0;
        add_d   = 1'b0;
        rm_d    = 1'b0;
        if (level != '0) begin
            step_c  = 2'd1;
            data_d  = head_symbol;
            valid_d = 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (is_com) state_d = ST_IN_OS;
                end
                ST_IN_OS: begin
                    if (is_skp) begin
                        // Deleting needs a second SKP behind the head so one survives.
                        if (want_rm && next_is_skp && (level > PW'(1))) begin
                            step_c  = 2'd2;
                            rm_d    = 1'b1;
                            state_d = ST_ADJ_DONE;
                        end else if (want_add) begin
                            step_c  = 2'd0;
                            add_d   = 1'b1;
                            state_d = ST_ADJ_DONE;
                        end
                    end else if (!is_com) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADJ_DONE: begin
                    if (is_com)       state_d = ST_IN_OS;
                    else if (!is_skp) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rd_step = rst ? 2'd0 : step_c;
    assign empty   = !rst && (level == '0);

    always_ff @(posedge read_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            add_q   <= 1'b0;
            rm_q    <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            add_q   <= add_d;
            rm_q    <= rm_d;
            fill_q  <= level;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign skp_added   = add_q;
    assign skp_removed = rm_q;
    assign fill_level  = fill_q;

endmodule
